// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the ID/EX control path: opcodes, functs, ALU codes,
// destination selects, FSM states and the registered control bundle.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_SLT     = 6'h2A;

    // Native ALU code width; the top zero-extends to its ALUOP_W parameter.
    localparam int ALU_CODE_W = 3;
    localparam logic [ALU_CODE_W-1:0] ALU_AND = 3'd0;
    localparam logic [ALU_CODE_W-1:0] ALU_OR  = 3'd1;
    localparam logic [ALU_CODE_W-1:0] ALU_ADD = 3'd2;
    localparam logic [ALU_CODE_W-1:0] ALU_LUI = 3'd3;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB = 3'd6;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT = 3'd7;

    localparam logic [1:0] REG_DST_RT  = 2'd0;
    localparam logic [1:0] REG_DST_RD  = 2'd1;
    localparam logic [1:0] REG_DST_R31 = 2'd2;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LU_WAIT = 2'd1,
        SQUASH  = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic [1:0]            reg_dst;
        logic                  jump;
        logic                  jr;
        logic                  branch;
        logic                  branch_ne;
        logic                  mem_read;
        logic                  mem_to_reg;
        logic [ALU_CODE_W-1:0] alu_op;
        logic                  reg_write;
        logic                  alu_src;
        logic                  mem_write;
        logic                  link;
        logic                  illegal;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational MIPS opcode/funct decoder producing one control bundle.
// Unknown encodings yield an all-zero bundle with only the illegal flag set.
module ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output ctrl_bundle_t bundle
);

    always_comb begin
        bundle = CTRL_BUBBLE;
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    FN_ADD, FN_ADDU, FN_AND, FN_OR, FN_SLT, FN_SUB: begin
                        bundle.reg_dst   = REG_DST_RD;
                        bundle.reg_write = 1'b1;
                        bundle.alu_src   = 1'b0;
                        case (funct)
                            FN_AND:  bundle.alu_op = ALU_AND;
                            FN_OR:   bundle.alu_op = ALU_OR;
                            FN_SLT:  bundle.alu_op = ALU_SLT;
                            FN_SUB:  bundle.alu_op = ALU_SUB;
                            default: bundle.alu_op = ALU_ADD;
                        endcase
                    end
                    FN_JR: begin
                        bundle.jump = 1'b1;
                        bundle.jr   = 1'b1;
                    end
                    default: bundle.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: begin
                bundle.reg_dst   = REG_DST_RT;
                bundle.alu_src   = 1'b1;
                bundle.reg_write = 1'b1;
                case (opcode)
                    OP_ORI:  bundle.alu_op = ALU_OR;
                    OP_LUI:  bundle.alu_op = ALU_LUI;
                    default: bundle.alu_op = ALU_ADD;
                endcase
            end
            // Loads also need the immediate offset and a write to rt.
            OP_LW: begin
                bundle.mem_read   = 1'b1;
                bundle.mem_to_reg = 1'b1;
                bundle.alu_op     = ALU_ADD;
                bundle.alu_src    = 1'b1;
                bundle.reg_write  = 1'b1;
                bundle.reg_dst    = REG_DST_RT;
            end
            OP_SW: begin
                bundle.mem_write = 1'b1;
                bundle.alu_op    = ALU_ADD;
                bundle.alu_src   = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                bundle.branch    = 1'b1;
                bundle.branch_ne = (opcode == OP_BNE);
                bundle.alu_op    = ALU_SUB;
            end
            OP_J: begin
                bundle.jump = 1'b1;
            end
            OP_JAL: begin
                bundle.jump      = 1'b1;
                bundle.link      = 1'b1;
                bundle.reg_write = 1'b1;
                bundle.reg_dst   = REG_DST_R31;
            end
            default: bundle.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_ctrl_unit.sv
// ID-stage control unit: decode, load-use stall, flush squash, ID/EX register.
// Optional ILLEGAL_TRAP_EN adds a sticky illegal_seen output.
module id_ex_ctrl_unit
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W  = 3,
    parameter int REG_AW   = 5,
    parameter int LU_STALL = 1,
    parameter int SQUASH_N = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [5:0]         id_opcode,
    input  logic [5:0]         id_funct,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic               ex_stall,
    input  logic               flush_in,
    output logic               id_stall,
    output logic               ex_valid,
    output logic [1:0]         ex_reg_dst,
    output logic               ex_jump,
    output logic               ex_jr,
    output logic               ex_branch,
    output logic               ex_branch_ne,
    output logic               ex_mem_read,
    output logic               ex_mem_to_reg,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_reg_write,
    output logic               ex_alu_src,
    output logic               ex_mem_write,
    output logic               ex_link,
    output logic [REG_AW-1:0]  ex_rt,
`ifdef ILLEGAL_TRAP_EN
    output logic               illegal_seen,
`endif
    output logic               ex_illegal
);

    localparam logic [1:0] LU_CNT_INIT = 2'(LU_STALL - 1);
    localparam logic [1:0] SQ_CNT_INIT = 2'(SQUASH_N - 1);

    ctrl_state_t  state, state_n;
    logic [1:0]   cnt, cnt_n;
    ctrl_bundle_t dec_bundle, id_bundle, next_bundle, ex_bundle;
    logic         id_issue_valid, next_valid, ex_load, hazard;
    logic [REG_AW-1:0] next_rt;

    ctrl_decode u_decode (
        .opcode (id_opcode),
        .funct  (id_funct),
        .bundle (dec_bundle)
    );

    assign id_bundle = id_valid ? dec_bundle : CTRL_BUBBLE;

`ifdef ILLEGAL_TRAP_EN
    assign id_issue_valid = id_valid & ~dec_bundle.illegal;
`else
    assign id_issue_valid = id_valid;
`endif

    assign hazard = ex_valid && ex_bundle.mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt)) && id_valid;

    // The last counted cycle of LU_WAIT/SQUASH (cnt==0) already issues the
    // waiting instruction, so exactly LU_STALL / SQUASH_N bubbles reach EX.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        id_stall    = 1'b0;
        ex_load     = 1'b1;
        next_bundle = CTRL_BUBBLE;
        next_valid  = 1'b0;
        next_rt     = '0;
        if (flush_in) begin
            state_n = SQUASH;
            cnt_n   = SQ_CNT_INIT;
        end else if (ex_stall) begin
            ex_load  = 1'b0;
            id_stall = 1'b1;
        end else if (state == LU_WAIT && cnt != 2'd0) begin
            id_stall = 1'b1;
            cnt_n    = cnt - 2'd1;
        end else if (state == SQUASH && cnt != 2'd0) begin
            cnt_n = cnt - 2'd1;
        end else if (hazard) begin
            state_n  = LU_WAIT;
            cnt_n    = LU_CNT_INIT;
            id_stall = 1'b1;
        end else begin
            state_n     = RUN;
            cnt_n       = 2'd0;
            next_bundle = id_bundle;
            next_valid  = id_issue_valid;
            next_rt     = id_valid ? id_rt : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= 2'd0;
            ex_bundle <= CTRL_BUBBLE;
            ex_valid  <= 1'b0;
            ex_rt     <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (ex_load) begin
                ex_bundle <= next_bundle;
                ex_valid  <= next_valid;
                ex_rt     <= next_rt;
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    // Sticky flag rises one cycle after an illegal instruction reaches EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_seen <= 1'b0;
        end else if (ex_bundle.illegal) begin
            illegal_seen <= 1'b1;
        end
    end
`endif

    assign ex_reg_dst    = ex_bundle.reg_dst;
    assign ex_jump       = ex_bundle.jump;
    assign ex_jr         = ex_bundle.jr;
    assign ex_branch     = ex_bundle.branch;
    assign ex_branch_ne  = ex_bundle.branch_ne;
    assign ex_mem_read   = ex_bundle.mem_read;
    assign ex_mem_to_reg = ex_bundle.mem_to_reg;
    assign ex_alu_op     = ALUOP_W'(ex_bundle.alu_op);
    assign ex_reg_write  = ex_bundle.reg_write;
    assign ex_alu_src    = ex_bundle.alu_src;
    assign ex_mem_write  = ex_bundle.mem_write;
    assign ex_link       = ex_bundle.link;
    assign ex_illegal    = ex_bundle.illegal;

endmodule
